// File: rtl/iir_sos_cascade_if.sv
// Sample/coefficient handshake bundle for iir_sos_cascade.
// master = sample source / controller side, slave = filter side.
interface iir_sos_cascade_if #(
    parameter int DATA_SIZE = 24,
    parameter int COEF_SIZE = 20
);
    logic signed [DATA_SIZE-1:0] data_in;
    logic                        sample_trig;
    logic                        coef_we;
    logic [7:0]                  coef_addr;
    logic signed [COEF_SIZE-1:0] coef_wdata;
    logic signed [DATA_SIZE-1:0] data_out;
    logic                        filter_done;
    logic                        busy;
    logic                        overrun;
    logic                        coef_wr_drop;

    modport master (
        output data_in, sample_trig, coef_we, coef_addr, coef_wdata,
        input  data_out, filter_done, busy, overrun, coef_wr_drop
    );

    modport slave (
        input  data_in, sample_trig, coef_we, coef_addr, coef_wdata,
        output data_out, filter_done, busy, overrun, coef_wr_drop
    );
endinterface

// File: rtl/iir_sos_cascade.sv
// Cascade of NUM_STAGES Direct-Form-I biquads sharing one multiplier, run-time coefficients.
// Optional macro IIR_SAT_EN: rounding results clamp instead of wrapping to DATA_SIZE bits.
module iir_sos_cascade #(
    parameter int COEF_SIZE  = 20,
    parameter int DATA_SIZE  = 24,
    parameter int COEF_FRAC  = 18,
    parameter int NUM_STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    iir_sos_cascade_if.slave bus
);
    localparam int ACC_W  = DATA_SIZE + COEF_SIZE + 3;
    localparam int PROD_W = DATA_SIZE + COEF_SIZE;
    localparam int STG_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [4:0]       NUM_STG_5 = 5'(NUM_STAGES);
    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    localparam logic signed [COEF_SIZE-1:0] COEF_ONE =
        {{(COEF_SIZE-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ROUND, S_GAIN, S_DONE} state_t;

    // Round half up at the binary point, then clamp or wrap to the sample width.
    function automatic logic signed [DATA_SIZE-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = (a + HALF) >>> COEF_FRAC;
`ifdef IIR_SAT_EN
        if (t > SAT_MAX) begin
            round_sat = SAT_MAX[DATA_SIZE-1:0];
        end else if (t < SAT_MIN) begin
            round_sat = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            round_sat = t[DATA_SIZE-1:0];
        end
`else
        round_sat = t[DATA_SIZE-1:0];
`endif
    endfunction

    state_t                      r_state;
    logic [STG_W-1:0]            r_stage;
    logic [2:0]                  r_tap;
    logic signed [DATA_SIZE-1:0] r_s, r_v, r_data_out;
    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_done, r_busy, r_overrun, r_drop;
    logic signed [DATA_SIZE-1:0] r_x1 [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] r_x2 [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] r_y1 [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] r_y2 [NUM_STAGES];
    logic signed [COEF_SIZE-1:0] r_coef [NUM_STAGES][6];

    logic signed [COEF_SIZE-1:0] w_mul_c;
    logic signed [DATA_SIZE-1:0] w_mul_d;
    logic                        w_sub;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext, w_term, w_acc_nxt;
    logic signed [DATA_SIZE-1:0] w_v, w_o;
    logic [3:0]                  w_wr_stage;
    logic [2:0]                  w_wr_idx;
    logic                        w_wr_valid;
    logic                        w_unused_addr_lsb;

    // Operand select for the shared multiplier: one tap per MAC cycle, gain in GAIN.
    always_comb begin
        w_mul_c = '0;
        w_mul_d = '0;
        w_sub   = 1'b0;
        case (r_state)
            S_MAC: begin
                case (r_tap)
                    3'd0: begin w_mul_c = r_coef[r_stage][3'd0]; w_mul_d = r_s;            end
                    3'd1: begin w_mul_c = r_coef[r_stage][3'd1]; w_mul_d = r_x1[r_stage];  end
                    3'd2: begin w_mul_c = r_coef[r_stage][3'd2]; w_mul_d = r_x2[r_stage];  end
                    3'd3: begin w_mul_c = r_coef[r_stage][3'd3]; w_mul_d = r_y1[r_stage]; w_sub = 1'b1; end
                    3'd4: begin w_mul_c = r_coef[r_stage][3'd4]; w_mul_d = r_y2[r_stage]; w_sub = 1'b1; end
                    default: begin w_mul_c = '0; w_mul_d = '0; end
                endcase
            end
            S_GAIN: begin
                w_mul_c = r_coef[r_stage][3'd5];
                w_mul_d = r_v;
            end
            default: begin
                w_mul_c = '0;
                w_mul_d = '0;
            end
        endcase
    end

    assign w_prod     = w_mul_c * w_mul_d;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_term     = w_sub ? -w_prod_ext : w_prod_ext;
    assign w_acc_nxt  = (r_tap == 3'd0) ? w_term : (r_acc + w_term);
    assign w_v        = round_sat(r_acc);
    assign w_o        = round_sat(w_prod_ext);

    assign w_wr_stage        = bus.coef_addr[7:4];
    assign w_wr_idx          = bus.coef_addr[3:1];
    assign w_unused_addr_lsb = bus.coef_addr[0];
    assign w_wr_valid        = ({1'b0, w_wr_stage} < NUM_STG_5) && (w_wr_idx < 3'd6);

    // Sequencer and datapath: MAC x5, ROUND, GAIN per stage, then one DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_tap      <= 3'd0;
            r_s        <= '0;
            r_v        <= '0;
            r_acc      <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (bus.sample_trig && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.sample_trig) begin
                        r_s     <= bus.data_in;
                        r_stage <= '0;
                        r_tap   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    if (r_tap == 3'd4) begin
                        r_tap   <= 3'd0;
                        r_state <= S_ROUND;
                    end else begin
                        r_tap <= r_tap + 3'd1;
                    end
                end
                S_ROUND: begin
                    // Recursion keeps the pre-gain section output.
                    r_v              <= w_v;
                    r_x2[r_stage]    <= r_x1[r_stage];
                    r_x1[r_stage]    <= r_s;
                    r_y2[r_stage]    <= r_y1[r_stage];
                    r_y1[r_stage]    <= w_v;
                    r_state          <= S_GAIN;
                end
                S_GAIN: begin
                    if (r_stage == LAST_STG) begin
                        r_data_out <= w_o;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_s     <= w_o;
                        r_stage <= r_stage + STG_W'(1'b1);
                        r_state <= S_MAC;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Coefficient bank: writes land only while idle; a valid write while busy is reported.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                for (int k = 0; k < 6; k++) begin
                    r_coef[i][k] <= (k == 0 || k == 5) ? COEF_ONE : '0;
                end
            end
        end else begin
            r_drop <= 1'b0;
            if (bus.coef_we && w_wr_valid) begin
                if (r_busy) begin
                    r_drop <= 1'b1;
                end else begin
                    r_coef[w_wr_stage[STG_W-1:0]][w_wr_idx] <= bus.coef_wdata;
                end
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.filter_done  = r_done;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;
    assign bus.coef_wr_drop = r_drop;
endmodule

// File: tb/tb_iir_sos_cascade.sv
// Randomized self-checking bench for iir_sos_cascade against an arithmetic cascade model.
module tb_iir_sos_cascade;
    localparam int DS = 24;
    localparam int CS = 20;
    localparam int CF = 18;
    localparam int NS = 4;
    localparam longint ONE  = longint'(1) <<< CF;
    localparam longint MAXV = (longint'(1) <<< (DS - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DS - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    iir_sos_cascade_if #(.DATA_SIZE(DS), .COEF_SIZE(CS)) bus();

    iir_sos_cascade #(.COEF_SIZE(CS), .DATA_SIZE(DS), .COEF_FRAC(CF), .NUM_STAGES(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    longint m_coef [NS][6];
    longint m_x1 [NS];
    longint m_x2 [NS];
    longint m_y1 [NS];
    longint m_y2 [NS];

    task automatic chk(input string tag, input longint got, input longint exp_v);
        n_total++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint rs(input longint a);
        longint t;
        logic signed [DS-1:0] w;
        t = (a + (longint'(1) <<< (CF - 1))) >>> CF;
`ifdef IIR_SAT_EN
        w = '0;
        if (t > MAXV) return MAXV;
        if (t < MINV) return MINV;
        return t;
`else
        w = t[DS-1:0];
        return longint'(w);
`endif
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 6; k++) m_coef[s][k] = (k == 0 || k == 5) ? ONE : 0;
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endfunction

    function automatic longint model_step(input longint x);
        longint s, acc, v;
        s = x;
        for (int k = 0; k < NS; k++) begin
            acc = m_coef[k][0] * s + m_coef[k][1] * m_x1[k] + m_coef[k][2] * m_x2[k]
                - m_coef[k][3] * m_y1[k] - m_coef[k][4] * m_y2[k];
            v = rs(acc);
            m_x2[k] = m_x1[k]; m_x1[k] = s;
            m_y2[k] = m_y1[k]; m_y1[k] = v;
            s = rs(v * m_coef[k][5]);
        end
        return s;
    endfunction

    task automatic wr_coef(input int st, input int idx, input longint val);
        logic signed [CS-1:0] vs;
        vs = val[CS-1:0];
        bus.coef_addr  = {st[3:0], idx[2:0], 1'b0};
        bus.coef_wdata = vs;
        bus.coef_we    = 1'b1;
        tick;
        bus.coef_we    = 1'b0;
        chk("wr_no_drop", bus.coef_wr_drop, 0);
        if (st < NS && idx < 6) m_coef[st][idx] = longint'(vs);
    endtask

    task automatic run_sample(input longint x, input string tag);
        longint exp_v;
        int n;
        bit busy_ok;
        exp_v = model_step(x);
        bus.data_in     = x[DS-1:0];
        bus.sample_trig = 1'b1;
        tick;
        bus.sample_trig = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!bus.filter_done && n < 60) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick;
            n++;
        end
        if (!bus.busy) busy_ok = 1'b0;
        chk({tag, "_latency"}, n, 7 * NS + 1);
        chk({tag, "_busy_window"}, busy_ok, 1);
        chk({tag, "_out"}, bus.data_out, exp_v);
        tick;
        chk({tag, "_done_pulse"}, bus.filter_done, 0);
        chk({tag, "_busy_fall"}, bus.busy, 0);
    endtask

    task automatic set_passthrough;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 6; k++) wr_coef(s, k, (k == 0 || k == 5) ? ONE : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint imp_exp [5];
        longint x, exp_v;
        int n, cnt;
        imp_exp = '{4096, 2048, 1024, 512, 256};
        bus.data_in = '0; bus.sample_trig = 1'b0; bus.coef_we = 1'b0;
        bus.coef_addr = '0; bus.coef_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_done", bus.filter_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_drop", bus.coef_wr_drop, 0);
        reset = 1'b1;
        tick;

        run_sample(64'sh100000, "pass");
        chk("pass_const", bus.data_out, 64'sh100000);

        // Half gain on stage 0, rounding half up.
        wr_coef(0, 5, 131072);
        run_sample(1000, "gain_a");  chk("gain_a_const", bus.data_out, 500);
        run_sample(1001, "gain_b");  chk("gain_b_const", bus.data_out, 501);
        run_sample(-1001, "gain_c"); chk("gain_c_const", bus.data_out, -500);
        wr_coef(0, 5, ONE);
        run_sample(0, "flush"); run_sample(0, "flush");

        // First-order decay through the feedback tap.
        wr_coef(0, 3, -131072);
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 4096 : 0, "impulse");
            chk("impulse_const", bus.data_out, imp_exp[i]);
        end
        wr_coef(0, 3, 0);
        run_sample(0, "flush"); run_sample(0, "flush");

        // Random coefficient sets and samples, plus ignored out-of-range writes.
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < NS; s++) begin
                wr_coef(s, 0, longint'(int'($urandom_range(0, 262143)) - 131072));
                wr_coef(s, 1, longint'(int'($urandom_range(0, 262143)) - 131072));
                wr_coef(s, 2, longint'(int'($urandom_range(0, 262143)) - 131072));
                wr_coef(s, 3, longint'(int'($urandom_range(0, 200000)) - 100000));
                wr_coef(s, 4, longint'(int'($urandom_range(0, 120000)) - 60000));
                wr_coef(s, 5, longint'(int'($urandom_range(0, 524287)) - 262144));
            end
            wr_coef(int'($urandom_range(NS, 15)), int'($urandom_range(0, 5)), 12345);
            wr_coef(int'($urandom_range(0, NS - 1)), int'($urandom_range(6, 7)), -777);
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 3)) tick;
                run_sample(longint'(int'($urandom_range(0, 8388606)) - 4194303), "rand");
            end
        end

        // Overflowing B0 times a full-scale input.
        set_passthrough();
        wr_coef(0, 0, 524287);
        run_sample(8388607, "ovf");
`ifdef IIR_SAT_EN
        chk("ovf_clamp", bus.data_out, 8388607);
`else
        chk("ovf_wrap_neg", bus.data_out[DS-1], 1);
`endif
        wr_coef(0, 0, ONE);

        // Trigger and coefficient write while busy.
        chk("ovr_pre", bus.overrun, 0);
        x = 777777;
        exp_v = model_step(x);
        bus.data_in = x[DS-1:0]; bus.sample_trig = 1'b1;
        tick;
        bus.sample_trig = 1'b0;
        repeat (4) tick;
        bus.data_in = 24'sd55; bus.sample_trig = 1'b1;
        tick;
        bus.sample_trig = 1'b0;
        chk("ovr_set", bus.overrun, 1);
        chk("drop_early", bus.coef_wr_drop, 0);
        bus.coef_addr = 8'h00; bus.coef_wdata = 20'sd65536; bus.coef_we = 1'b1;
        tick;
        bus.coef_we = 1'b0;
        chk("drop_pulse", bus.coef_wr_drop, 1);
        tick;
        chk("drop_single", bus.coef_wr_drop, 0);
        n = 8;
        while (!bus.filter_done && n < 60) begin tick; n++; end
        chk("ovr_latency", n, 7 * NS + 1);
        chk("ovr_out", bus.data_out, exp_v);
        cnt = 0;
        repeat (40) begin tick; if (bus.filter_done) cnt++; end
        chk("ovr_no_second_done", cnt, 0);
        chk("ovr_sticky", bus.overrun, 1);
        run_sample(-2000000, "coef_kept");

        // Reset in mid computation.
        bus.data_in = 24'sd123456; bus.sample_trig = 1'b1;
        tick;
        bus.sample_trig = 1'b0;
        repeat (9) tick;
        reset = 1'b0;
        #1;
        chk("abort_data_out", bus.data_out, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.filter_done, 0);
        chk("abort_overrun", bus.overrun, 0);
        model_reset();
        repeat (3) tick;
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin tick; if (bus.filter_done) cnt++; end
        chk("abort_no_done", cnt, 0);
        run_sample(-3141592, "post_rst");
        chk("post_rst_exact", bus.data_out, -3141592);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
